// File: rtl/data_break_ctl.sv
// data_break_ctl
// Single-cycle data-break (DMA) controller between the RK8E disk controller
// and main memory. A level request from the disk is held pending until the
// CPU reaches a major-state boundary; then one two-state break cycle
// (DB0, DB1) is run against the memory port, followed by a one-cycle GAP
// that lets the disk drop its request after it has seen DB1.
//
// Optional feature macro: DB_TIMEOUT_EN
//   defined   : a pending request that sees no boundary within TIMEOUT_CYCLES
//               PEND cycles is abandoned and the sticky db_timeout flag sets.
//   undefined : PEND waits indefinitely and db_timeout is tied to 0.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   clear             IOCLR; abandons a break that has not started yet
//   data_break        disk break request (level)
//   to_disk           1 = memory->disk (read), 0 = disk->memory (write)
//   dma_addr          15-bit break address (field + address)
//   dma_wdata         disk word to be written to memory
//   cpu_boundary      CPU may yield the memory this cycle
//   mem_rdata         memory read data, valid the cycle after mem_rd
//   break_in_prog     CPU must hold; the break owns memory
//   db_state          DB0/DB1 state code for the disk's state input, else 0
//   mem_addr          memory address (latched break address)
//   mem_wdata         memory write data (latched disk word)
//   mem_rd, mem_we    one-cycle read strobe (DB0) / write strobe (DB1)
//   dma_rdata         last word read for the disk
//   db_timeout        sticky watchdog flag
//
// State table
//   state | meaning
//   IDLE  | no request outstanding; data_break sampled here only
//   PEND  | request seen, CPU held, waiting for cpu_boundary
//   DB0   | break state 0: address out, read strobe for reads
//   DB1   | break state 1: write strobe for writes, read data captured
//   GAP   | one idle cycle so the disk can drop data_break after DB1

module data_break_ctl #(
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [4:0] DB0_CODE       = 5'b10000,
  parameter logic [4:0] DB1_CODE       = 5'b10001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        data_break,
  input  logic        to_disk,
  input  logic [0:14] dma_addr,
  input  logic [0:11] dma_wdata,
  input  logic        cpu_boundary,
  input  logic [0:11] mem_rdata,
  output logic        break_in_prog,
  output logic [4:0]  db_state,
  output logic [0:14] mem_addr,
  output logic [0:11] mem_wdata,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [0:11] dma_rdata,
  output logic        db_timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("data_break_ctl: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_DB0,
    S_DB1,
    S_GAP
  } state_e;

  state_e      state_q, state_d;
  logic [0:14] addr_q, addr_d;
  logic [0:11] wdata_q, wdata_d;
  logic        dir_q, dir_d;
  logic [0:11] rdata_q, rdata_d;
  logic        bip_q;
  logic [4:0]  dbs_q;
  logic        rd_q;
  logic        we_q;
  logic        tmo_fire;

`ifdef DB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;
  logic             tmo_hit;

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dir_d    = dir_q;
    rdata_d  = rdata_q;
    tmo_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_break) state_d = S_PEND;
      end
      S_PEND: begin
        // clear and a dropped request both abandon the break before any
        // memory access; either beats a simultaneous boundary.
        if (clear || !data_break) begin
          state_d = S_IDLE;
        end else if (cpu_boundary) begin
          addr_d  = dma_addr;
          wdata_d = dma_wdata;
          dir_d   = to_disk;
          state_d = S_DB0;
        end
`ifdef DB_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = S_IDLE;
        end
`endif
      end
      S_DB0: state_d = S_DB1;
      S_DB1: begin
        if (dir_q) rdata_d = mem_rdata;
        state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // register they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      dir_q   <= 1'b0;
      rdata_q <= '0;
      bip_q   <= 1'b0;
      dbs_q   <= 5'd0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
`ifdef DB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dir_q   <= dir_d;
      rdata_q <= rdata_d;
      bip_q   <= (state_d == S_PEND) || (state_d == S_DB0) || (state_d == S_DB1);
      dbs_q   <= (state_d == S_DB0) ? DB0_CODE :
                 (state_d == S_DB1) ? DB1_CODE : 5'd0;
      rd_q    <= (state_d == S_DB0) && dir_d;
      we_q    <= (state_d == S_DB1) && !dir_d;
`ifdef DB_TIMEOUT_EN
      // Any cycle outside PEND zeroes the count, so it starts at 0 on entry.
      cnt_q   <= (state_q == S_PEND) ? cnt_q + 1'b1 : '0;
      if (clear)         tmo_q <= 1'b0;
      else if (tmo_fire) tmo_q <= 1'b1;
`endif
    end
  end

  assign break_in_prog = bip_q;
  assign db_state      = dbs_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_rd        = rd_q;
  assign mem_we        = we_q;
  assign dma_rdata     = rdata_q;
`ifdef DB_TIMEOUT_EN
  assign db_timeout    = tmo_q;
`else
  assign db_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_data_break_ctl.sv
module tb_data_break_ctl;

  localparam int         TMO  = 16;
  localparam logic [4:0] DB0C = 5'b10000;
  localparam logic [4:0] DB1C = 5'b10001;
`ifdef DB_TIMEOUT_EN
  localparam int LONG_DLY = 14;
`else
  localparam int LONG_DLY = 20;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        data_break;
  logic        to_disk;
  logic [0:14] dma_addr;
  logic [0:11] dma_wdata;
  logic        cpu_boundary;
  logic [0:11] mem_rdata;
  logic        break_in_prog;
  logic [4:0]  db_state;
  logic [0:14] mem_addr;
  logic [0:11] mem_wdata;
  logic        mem_rd;
  logic        mem_we;
  logic [0:11] dma_rdata;
  logic        db_timeout;

  data_break_ctl #(
    .TIMEOUT_CYCLES(TMO),
    .DB0_CODE(DB0C),
    .DB1_CODE(DB1C)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .data_break(data_break),
    .to_disk(to_disk),
    .dma_addr(dma_addr),
    .dma_wdata(dma_wdata),
    .cpu_boundary(cpu_boundary),
    .mem_rdata(mem_rdata),
    .break_in_prog(break_in_prog),
    .db_state(db_state),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd(mem_rd),
    .mem_we(mem_we),
    .dma_rdata(dma_rdata),
    .db_timeout(db_timeout)
  );

  always #5 clk = ~clk;

  // Memory the DUT talks to: registered read data, valid the cycle after mem_rd.
  logic [11:0] mem [0:32767];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd ? mem[mem_addr] : 12'o6543;
  end

  // Reference model: what memory should contain, word by word.
  logic [11:0] ref_mem [int];
  logic [11:0] exp_rdata;
  logic        exp_tmo;
  int          n_cmp;
  int          n_err;

  function automatic logic [11:0] pat(input int a);
    return 12'(a) ^ 12'o5252;
  endfunction

  function automatic logic [11:0] ref_read(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic e_bip, input logic [4:0] e_dbs,
                             input logic e_rd, input logic e_we);
    chk({tag, ".break_in_prog"}, 32'(break_in_prog), 32'(e_bip));
    chk({tag, ".db_state"}, 32'(db_state), 32'(e_dbs));
    chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(e_rd));
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(e_we));
    chk({tag, ".dma_rdata"}, 32'(dma_rdata), 32'(exp_rdata));
    chk({tag, ".db_timeout"}, 32'(db_timeout), 32'(exp_tmo));
  endtask

  // Entered and left just after a negedge with the DUT idle. One break:
  // dly extra PEND cycles before the boundary, optional clear during DB0,
  // optional request held high across GAP (back-to-back).
  task automatic run_break(input string tag, input logic [0:14] a, input logic [11:0] d,
                           input logic dir, input int dly, input bit clr_db0, input bit hold);
    check_state({tag, ".idle0"}, 1'b0, 5'd0, 1'b0, 1'b0);
    data_break   = 1'b1;
    cpu_boundary = 1'b0;
    to_disk      = 1'($urandom_range(0, 1));
    dma_addr     = 15'($urandom);
    dma_wdata    = 12'($urandom);
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      check_state({tag, ".pend"}, 1'b1, 5'd0, 1'b0, 1'b0);
      if (i == dly) begin
        cpu_boundary = 1'b1;
        dma_addr     = a;
        dma_wdata    = d;
        to_disk      = dir;
      end else begin
        dma_addr  = 15'($urandom);
        dma_wdata = 12'($urandom);
      end
    end
    @(negedge clk);
    check_state({tag, ".db0"}, 1'b1, DB0C, dir, 1'b0);
    chk({tag, ".db0.mem_addr"}, 32'(mem_addr), 32'(a));
    cpu_boundary = 1'($urandom_range(0, 1));
    dma_addr     = ~a;
    dma_wdata    = ~d;
    to_disk      = ~dir;
    clear        = clr_db0;
    if (clr_db0) exp_tmo = 1'b0;
    @(negedge clk);
    check_state({tag, ".db1"}, 1'b1, DB1C, 1'b0, !dir);
    chk({tag, ".db1.mem_addr"}, 32'(mem_addr), 32'(a));
    if (!dir) begin
      chk({tag, ".db1.mem_wdata"}, 32'(mem_wdata), 32'(d));
      ref_mem[int'(a)] = d;
    end
    clear        = 1'b0;
    cpu_boundary = 1'b0;
    if (!hold) data_break = 1'b0;
    @(negedge clk);
    if (dir) exp_rdata = ref_read(int'(a));
    check_state({tag, ".gap"}, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_state({tag, ".idle5"}, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Request abandoned in PEND, either by clear (with a boundary present) or
  // by the disk dropping data_break.
  task automatic pend_abort(input string tag, input bit by_clear);
    check_state({tag, ".idle0"}, 1'b0, 5'd0, 1'b0, 1'b0);
    data_break   = 1'b1;
    cpu_boundary = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_state({tag, ".pend"}, 1'b1, 5'd0, 1'b0, 1'b0);
    end
    if (by_clear) begin
      clear        = 1'b1;
      cpu_boundary = 1'b1;
      exp_tmo      = 1'b0;
    end else begin
      data_break = 1'b0;
    end
    @(negedge clk);
    check_state({tag, ".idle1"}, 1'b0, 5'd0, 1'b0, 1'b0);
    clear        = 1'b0;
    cpu_boundary = 1'b0;
    data_break   = 1'b0;
    @(negedge clk);
    check_state({tag, ".idle2"}, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    exp_rdata = 12'o0000;
    exp_tmo   = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = pat(i);
    mem[15'o00200]     = 12'o1234;
    ref_mem[15'o00200] = 12'o1234;

    // Reset wins over an active request.
    reset        = 1'b1;
    clear        = 1'b0;
    data_break   = 1'b1;
    cpu_boundary = 1'b1;
    to_disk      = 1'b1;
    dma_addr     = 15'o77777;
    dma_wdata    = 12'o7777;
    repeat (3) @(negedge clk);
    check_state("reset", 1'b0, 5'd0, 1'b0, 1'b0);
    chk("reset.mem_addr", 32'(mem_addr), 32'd0);
    chk("reset.mem_wdata", 32'(mem_wdata), 32'd0);
    reset      = 1'b0;
    data_break = 1'b0;
    @(negedge clk);

    run_break("write", 15'o12345, 12'o7070, 1'b0, 0, 1'b0, 1'b0);
    run_break("read", 15'o00200, 12'o0000, 1'b1, 0, 1'b0, 1'b0);
    chk("read.dma_rdata", 32'(dma_rdata), 32'o1234);
    run_break("readback", 15'o12345, 12'o0000, 1'b1, 1, 1'b0, 1'b0);
    run_break("long_wait", 15'o40001, 12'o0505, 1'b0, LONG_DLY, 1'b0, 1'b0);
    pend_abort("clr_pend", 1'b1);
    pend_abort("drop_pend", 1'b0);
    run_break("clr_db0", 15'o70707, 12'o1357, 1'b0, 0, 1'b1, 1'b0);
    run_break("clr_db0_rd", 15'o70707, 12'o0000, 1'b1, 0, 1'b0, 1'b0);
    run_break("b2b_a", 15'o00011, 12'o4321, 1'b0, 0, 1'b0, 1'b1);
    run_break("b2b_b", 15'o00011, 12'o0000, 1'b1, 0, 1'b0, 1'b0);

    // Watchdog.
    check_state("tmo.idle0", 1'b0, 5'd0, 1'b0, 1'b0);
    data_break   = 1'b1;
    cpu_boundary = 1'b0;
`ifdef DB_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      check_state("tmo.pend", 1'b1, 5'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    exp_tmo = 1'b1;
    check_state("tmo.fired", 1'b0, 5'd0, 1'b0, 1'b0);
    data_break = 1'b0;
    @(negedge clk);
    check_state("tmo.sticky", 1'b0, 5'd0, 1'b0, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear   = 1'b0;
    exp_tmo = 1'b0;
    check_state("tmo.cleared", 1'b0, 5'd0, 1'b0, 1'b0);
`else
    for (int i = 0; i < TMO + 9; i++) begin
      @(negedge clk);
      check_state("notmo.pend", 1'b1, 5'd0, 1'b0, 1'b0);
    end
    data_break = 1'b0;
    @(negedge clk);
    check_state("notmo.idle", 1'b0, 5'd0, 1'b0, 1'b0);
`endif
    @(negedge clk);

    // Randomized breaks; a small address pool makes reads hit earlier writes.
    for (int n = 0; n < 40; n++) begin
      logic [0:14] ra;
      logic [11:0] rd;
      logic        rdir;
      int          rdly;
      bit          rclr;
      bit          rhold;
      ra    = ($urandom_range(0, 1) == 1) ? 15'($urandom_range(0, 7)) : 15'($urandom);
      rd    = 12'($urandom);
      rdir  = 1'($urandom_range(0, 1));
      rdly  = int'($urandom_range(0, 5));
      rclr  = ($urandom_range(0, 3) == 0);
      rhold = (n != 39) && ($urandom_range(0, 1) == 1);
      run_break("rand", ra, rd, rdir, rdly, rclr, rhold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_break_ctl.md
# data_break_ctl

Single-cycle data-break (DMA) controller sitting between the RK8E disk controller and main memory. It accepts the disk's `data_break` request, the 15-bit break address, and the transfer direction. It then waits for the CPU to reach a major-state boundary and runs one two-state break cycle (DB0, DB1) against the memory port. Disk-to-memory words are written; memory-to-disk words are read and returned on `dma_rdata`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096: cycles a request may stay pending before the watchdog fires (only with `DB_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  IOCLR; abandons a pending (not yet started) break.
- `data_break`  in  1  break request from disk; level, held until DB1 is seen.
- `to_disk`  in  1  1 = memory→disk (read), 0 = disk→memory (write).
- `dma_addr`  in  [0:14]  break address (field + 12-bit address).
- `dma_wdata`  in  [0:11]  disk data to memory.
- `cpu_boundary`  in  1  CPU is at the end of a major state and may yield.
- `mem_rdata`  in  [0:11]  memory read data, valid the cycle after `mem_rd`.
- `break_in_prog`  out  1  CPU must hold; break owns memory.
- `db_state`  out  [4:0]  break state code (`DB0`/`DB1` from parameters.v; else 0), fed to the disk's `state` input path.
- `mem_addr`  out  [0:14]  memory address.
- `mem_wdata`  out  [0:11]  memory write data.
- `mem_rd`  out  1  memory read strobe.
- `mem_we`  out  1  memory write strobe.
- `dma_rdata`  out  [0:11]  word read for disk; held until next read break.
- `db_timeout`  out  1  sticky watchdog flag (constant 0 without `DB_TIMEOUT_EN`).

## Operation
FSM states: IDLE, PEND, DB0, DB1, GAP.
- IDLE: if `data_break`=1 → PEND.
- PEND: `break_in_prog`=1. On `clear`=1 → IDLE (clear wins over `cpu_boundary`). Otherwise, on `cpu_boundary`=1, latch `dma_addr`, `to_disk`, and `dma_wdata` → DB0.
- DB0: `db_state`=DB0. Drive `mem_addr` from the latch. If read, `mem_rd`=1. → DB1.
- DB1: `db_state`=DB1. If read, capture `mem_rdata` into `dma_rdata`. If write, `mem_we`=1 with `mem_wdata` = latched word. → GAP.
- GAP: one cycle, `break_in_prog`=0. Lets the disk drop `data_break` after seeing DB1. → IDLE; the request is re-sampled there, never in GAP.
- `clear` in DB0/DB1/GAP is ignored; the cycle completes (no torn memory access).
- `data_break` falling while in PEND: → IDLE, no memory access.
- Addresses use all 15 bits; no arithmetic or increment is done here (the disk side owns address advance).

## Timing
- Reset values: state IDLE; `break_in_prog`, `mem_rd`, `mem_we`, `db_timeout` = 0; `db_state`=0; `mem_addr`, `mem_wdata`, `dma_rdata` = 0.
- All outputs are registered (decoded from the state register).
- Request at edge t → PEND at t+1. Boundary at t+1 → DB0 at t+2, DB1 at t+3, GAP at t+4, IDLE at t+5.
- Minimum spacing between back-to-back breaks is 5 cycles with `cpu_boundary` tied high.
- `mem_addr` is stable through DB0 and DB1. `mem_rd` lasts exactly one cycle (DB0). `mem_we` lasts exactly one cycle (DB1).
- `dma_rdata` updates at the end of DB1 and is visible the GAP cycle onward.

## Configuration
- `DB_TIMEOUT_EN` defined:
  - a counter clears on PEND entry and increments each PEND cycle.
  - When it reaches `TIMEOUT_CYCLES-1` with no boundary, the FSM → IDLE and `db_timeout` sets.
  - `db_timeout` stays set until `reset` or `clear`.
- Not defined: no counter exists, PEND waits indefinitely, and `db_timeout` is tied to 0.

## Test plan
- Write break: `dma_addr`=15'o12345, `dma_wdata`=12'o7070, `to_disk`=0, `cpu_boundary`=1 → `mem_we` pulses in DB1 with addr 12345 and data 7070; back in IDLE at t+5.
- Read break: memory[15'o00200]=12'o1234, `to_disk`=1 → `mem_rd` in DB0; `dma_rdata`=1234 from GAP on; `mem_we` never asserts.
- Boundary delay: hold `cpu_boundary`=0 for 20 cycles → `break_in_prog`=1 for all 20, no memory strobes; DB0 exactly one cycle after the boundary rises.
- Clear: `clear` in PEND → IDLE, no strobes. `clear` in DB0 → write still completes in DB1.
- Back-to-back: `data_break` held high across GAP → second break starts at IDLE (PEND on the following cycle), never skipping GAP.
- `DB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, boundary never asserted → `db_timeout`=1 and state IDLE after 16 PEND cycles. Without the macro, PEND persists past 16 cycles and `db_timeout`=0.
